// File: rtl/apb_slave_regfile.sv
// APB3 completer: NUM_REGS RW config registers plus one read-only status word, programmable wait states.
// Completion WAIT_STATES+1 cycles after setup; pready/prdata/pslverr registered, writes commit on the completing edge.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 24,
    parameter int NUM_REGS    = 16,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_STATES = 0
) (
    input  logic                           pclk,
    input  logic                           reset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [DATA_WIDTH-1:0]          status_in
);

    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STATUS_OFF = ADDR_WIDTH'(NUM_REGS);
    localparam logic [3:0]            WS         = 4'(WAIT_STATES);

    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            wcnt;

    logic [ADDR_WIDTH-1:0] dec_addr, off;
    logic                  dec_write, is_status, dec_err;
    logic [NUM_REGS-1:0]   hit;
    logic [DATA_WIDTH-1:0] rd_mux, dec_dat;
    logic                  setup, arm, done;

    // Decode live bus in IDLE (zero-wait completion), latched transfer otherwise.
    always_comb begin
        dec_addr  = (state == IDLE) ? paddr : addr_q;
        dec_write = (state == IDLE) ? pwrite : write_q;
        off       = dec_addr - BASE;
        hit       = '0;
        rd_mux    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            hit[i] = (off == ADDR_WIDTH'(i));
            rd_mux = rd_mux | (cfg_regs[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{hit[i]}});
        end
        is_status = (off == STATUS_OFF);
        dec_err   = !(|hit) && !(is_status && !dec_write);
        dec_dat   = '0;
        if (!dec_write) begin
            if (|hit)
                dec_dat = rd_mux;
            else if (is_status)
                dec_dat = status_in;
        end
    end

    assign setup = (state == IDLE) && psel && !penable;
    assign done  = (state == ACCESS) && psel && pready;
    assign arm   = (setup && (WS == 4'd0)) ||
                   ((state == ACCESS) && psel && !pready && (wcnt == 4'd1));

    always_ff @(posedge pclk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (setup) state_nxt = ACCESS;
            ACCESS: if (!psel || pready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            wcnt     <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;
            cfg_regs <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            pready   <= arm;
            prdata   <= arm ? dec_dat : '0;
            pslverr  <= arm & dec_err;
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
                wcnt    <= WS;
            end
            if ((state == ACCESS) && psel && !pready && (wcnt != 4'd0))
                wcnt <= wcnt - 4'd1;
            if (done && write_q && !dec_err) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (hit[i]) begin
                        cfg_regs[i*DATA_WIDTH +: DATA_WIDTH] <= wdata_q;
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized scoreboard bench for apb_slave_regfile: three instances with 0, 3 and 2 wait states.
module tb_apb_slave_regfile;
    localparam int AW = 8;
    localparam int DW = 24;
    localparam int NR = 16;
    localparam int ND = 3;
    localparam int BASE = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic          rst     [ND];
    logic          psel    [ND];
    logic          penable [ND];
    logic          pwrite  [ND];
    logic [AW-1:0] paddr   [ND];
    logic [DW-1:0] pwdata  [ND];
    logic [DW-1:0] status  [ND];
    logic [DW-1:0] prdata  [ND];
    logic          pready  [ND];
    logic          pslverr [ND];
    logic [NR*DW-1:0] cfg  [ND];
    logic [NR-1:0] wp      [ND];

    apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(0)) u0 (
        .pclk(clk), .reset(rst[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]), .cfg_regs(cfg[0]), .wr_pulse(wp[0]), .status_in(status[0]));
    apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(3)) u1 (
        .pclk(clk), .reset(rst[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]), .cfg_regs(cfg[1]), .wr_pulse(wp[1]), .status_in(status[1]));
    apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .BASE_ADDR(BASE), .WAIT_STATES(2)) u2 (
        .pclk(clk), .reset(rst[2]), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2]), .cfg_regs(cfg[2]), .wr_pulse(wp[2]), .status_in(status[2]));

    typedef struct { int k; logic [DW-1:0] dat; logic err; } rsp_t;
    typedef struct { int k; int idx; logic [DW-1:0] val; } pls_t;
    rsp_t rsp_q[$];
    pls_t pls_q[$];
    logic [DW-1:0] mregs [ND][NR];

    int errors = 0;
    int checks = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 2;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: register file semantics from the address map, applied at issue time.
    task automatic issue(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rsp_t e;
        pls_t p;
        int off;
        off   = int'(a - AW'(BASE));
        e.k   = k;
        e.dat = '0;
        e.err = 1'b0;
        if (wr) begin
            if (off < NR) begin
                mregs[k][off] = d;
                p.k = k; p.idx = off; p.val = d;
                pls_q.push_back(p);
            end else
                e.err = 1'b1;
        end else begin
            if (off < NR)       e.dat = mregs[k][off];
            else if (off == NR) e.dat = status[k];
            else                e.err = 1'b1;
        end
        rsp_q.push_back(e);
    endtask

    task automatic xfer(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int t);
        int n;
        n = 0;
        @(posedge clk); #1;
        t = cyc;
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
        issue(k, wr, a, d);
        @(posedge clk); #1;
        penable[k] = 1'b1;
        paddr[k]   = AW'($urandom);
        pwdata[k]  = DW'($urandom);
        while (1) begin
            @(negedge clk);
            if (pready[k]) break;
            n++;
            if (n > 40) begin
                errors++; checks++;
                $display("FAIL timeout dut%0d: pready never rose", k);
                break;
            end
        end
        chk($sformatf("wait_cycles dut%0d", k), 64'(n), 64'(ws_of(k)));
    endtask

    task automatic idle(input int k);
        @(posedge clk); #1;
        psel[k] = 1'b0; penable[k] = 1'b0;
    endtask

    // Monitor: pops expectations whenever a completion or write strobe appears.
    initial begin
        rsp_t e;
        pls_t p;
        forever begin
            @(negedge clk);
            for (int k = 0; k < ND; k++) begin
                if (!rst[k]) begin
                    if (pready[k]) begin
                        if (rsp_q.size() == 0 || rsp_q[0].k != k) begin
                            errors++; checks++;
                            $display("FAIL unexpected_pready dut%0d: got pready=1 expected no transfer", k);
                        end else begin
                            e = rsp_q.pop_front();
                            chk($sformatf("prdata dut%0d", k), 64'(prdata[k]), 64'(e.dat));
                            chk($sformatf("pslverr dut%0d", k), 64'(pslverr[k]), 64'(e.err));
                        end
                    end else begin
                        chk($sformatf("idle_zero dut%0d", k), 64'({prdata[k], pslverr[k]}), 64'(0));
                    end
                    if (wp[k] != '0) begin
                        if (pls_q.size() == 0 || pls_q[0].k != k) begin
                            errors++; checks++;
                            $display("FAIL unexpected_wr_pulse dut%0d: got %0h expected 0", k, wp[k]);
                        end else begin
                            p = pls_q.pop_front();
                            chk($sformatf("wr_pulse dut%0d", k), 64'(wp[k]), 64'(NR'(1) << p.idx));
                            chk($sformatf("cfg_at_pulse dut%0d", k), 64'(cfg[k][p.idx*DW +: DW]), 64'(p.val));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int t, tprev;
        for (int k = 0; k < ND; k++) begin
            rst[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; pwdata[k] = '0; status[k] = '0;
            for (int i = 0; i < NR; i++) mregs[k][i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            chk("reset_pready", 64'(pready[k]), 64'(0));
            chk("reset_prdata", 64'(prdata[k]), 64'(0));
            chk("reset_pslverr", 64'(pslverr[k]), 64'(0));
            chk("reset_wr_pulse", 64'(wp[k]), 64'(0));
            chk("reset_cfg_zero", 64'(cfg[k] != '0), 64'(0));
        end
        @(posedge clk); #1;
        for (int k = 0; k < ND; k++) rst[k] = 1'b0;

        // Write then immediate read-back; other registers read zero.
        xfer(0, 1, 8'd3, 24'hABCDEF, t);
        xfer(0, 0, 8'd3, 24'h0, t);
        for (int i = 0; i < NR; i++)
            if (i != 3) xfer(0, 0, AW'(i), 24'h0, t);
        idle(0);

        // Status read with three wait states.
        status[1] = 24'h123456;
        xfer(1, 0, 8'd16, 24'h0, t);
        idle(1);

        // Errored writes and an out-of-map read.
        xfer(0, 1, 8'd16, 24'h111111, t);
        xfer(0, 1, 8'd200, 24'h111111, t);
        xfer(0, 0, 8'd200, 24'h0, t);
        idle(0);

        // Reset in the middle of a two-wait-state write aborts it.
        xfer(2, 1, 8'd7, 24'h5A5A5A, t);
        idle(2);
        @(posedge clk); #1;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'd5; pwdata[2] = 24'h00FFFF;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        chk("abort_access1_pready", 64'(pready[2]), 64'(0));
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(negedge clk);
        chk("abort_pready", 64'(pready[2]), 64'(0));
        chk("abort_prdata", 64'(prdata[2]), 64'(0));
        chk("abort_pslverr", 64'(pslverr[2]), 64'(0));
        chk("abort_wr_pulse", 64'(wp[2]), 64'(0));
        chk("abort_cfg_zero", 64'(cfg[2] != '0), 64'(0));
        psel[2] = 1'b0; penable[2] = 1'b0;
        for (int i = 0; i < NR; i++) mregs[2][i] = '0;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        xfer(2, 1, 8'd5, 24'h00FFFF, t);
        idle(2);

        // Back-to-back stream: two cycles per transfer.
        tprev = 0;
        for (int i = 0; i < NR; i++) begin
            xfer(0, 1, AW'(i), DW'(i), t);
            if (i > 0) chk("stream_spacing", 64'(t - tprev), 64'(2));
            tprev = t;
        end
        for (int i = 0; i < NR; i++) xfer(0, 0, AW'(i), 24'h0, t);
        idle(0);

        // Randomized traffic on every instance.
        for (int k = 0; k < ND; k++) begin
            for (int n = 0; n < 60; n++) begin
                logic [AW-1:0] a;
                a = ($urandom_range(0, 2) == 0) ? AW'($urandom) : AW'($urandom_range(0, NR + 1));
                status[k] = DW'($urandom);
                xfer(k, 1'($urandom), a, DW'($urandom), t);
                if ($urandom_range(0, 2) == 0) idle(k);
            end
            idle(k);
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'(0));
        chk("pulse_queue_drained", 64'(pls_q.size()), 64'(0));
        for (int k = 0; k < ND; k++)
            for (int i = 0; i < NR; i++)
                chk($sformatf("final_cfg dut%0d reg%0d", k, i), 64'(cfg[k][i*DW +: DW]), 64'(mregs[k][i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
